// File: rtl/axis_rx_drop_fifo_if.sv
// Stream bundle for the RX drop FIFO: MAC-side input stream plus consumer-side output stream.
// The DUT uses the slave view; whoever feeds and drains the FIFO uses the master view.
interface axis_rx_drop_fifo_if #(
   parameter int AXIS_WIDTH = 64,
   parameter int KEEP_WIDTH = AXIS_WIDTH / 8
);
   logic [AXIS_WIDTH-1:0] s_axis_tdata_i;
   logic [KEEP_WIDTH-1:0] s_axis_tkeep_i;
   logic                  s_axis_tvalid_i;
   logic                  s_axis_tlast_i;
   logic                  s_axis_tuser_i;
   logic [AXIS_WIDTH-1:0] m_axis_tdata_o;
   logic [KEEP_WIDTH-1:0] m_axis_tkeep_o;
   logic                  m_axis_tvalid_o;
   logic                  m_axis_tlast_o;
   logic                  m_axis_tready_i;

   modport slave (
      input  s_axis_tdata_i, s_axis_tkeep_i, s_axis_tvalid_i, s_axis_tlast_i, s_axis_tuser_i,
      input  m_axis_tready_i,
      output m_axis_tdata_o, m_axis_tkeep_o, m_axis_tvalid_o, m_axis_tlast_o
   );

   modport master (
      output s_axis_tdata_i, s_axis_tkeep_i, s_axis_tvalid_i, s_axis_tlast_i, s_axis_tuser_i,
      output m_axis_tready_i,
      input  m_axis_tdata_o, m_axis_tkeep_o, m_axis_tvalid_o, m_axis_tlast_o
   );
endinterface

// File: rtl/axis_rx_drop_fifo.sv
// Store-and-forward RX packet FIFO: frames become visible only once committed with a good tuser.
// Optional per-frame statistics counters are enabled by defining RX_DROP_FIFO_STATS_EN.
module axis_rx_drop_fifo #(
   parameter int AXIS_WIDTH = 64,
   parameter int KEEP_WIDTH = AXIS_WIDTH / 8,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   axis_rx_drop_fifo_if.slave    bus,
   output logic                  frame_received_o,
   output logic                  frame_dropped_o
`ifdef RX_DROP_FIFO_STATS_EN
   ,
   output logic [31:0]           good_frames_o,
   output logic [31:0]           bad_frames_o,
   output logic [31:0]           overflow_frames_o
`endif
);
   localparam int PW = DEPTH_LOG2 + 1;
   localparam int WW = AXIS_WIDTH + KEEP_WIDTH + 1;
   localparam logic [PW-1:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {SYNC, IDLE, FRAME, DROP} wrState_t;

   logic [WW-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   wrState_t      r_state, w_stateNext;
   logic [PW-1:0] r_wrPtr, w_wrPtrNext;
   logic [PW-1:0] r_wrCommit, w_wrCommitNext;
   logic [PW-1:0] r_rdPtr;
   logic          w_full, w_write, w_good, w_bad, w_ovf;
   logic          r_frameReceived, r_frameDropped;
   logic [WW-1:0] r_skid [2];
   logic          r_head;
   logic [1:0]    r_count;
   logic          w_pop, w_push, w_tail;

   assign w_full = (r_wrPtr - r_rdPtr) == FULL_LEVEL;

   always_comb begin
      w_stateNext    = r_state;
      w_wrPtrNext    = r_wrPtr;
      w_wrCommitNext = r_wrCommit;
      w_write        = 1'b0;
      w_good         = 1'b0;
      w_bad          = 1'b0;
      w_ovf          = 1'b0;
      case (r_state)
         SYNC: begin
            if (!bus.s_axis_tvalid_i || bus.s_axis_tlast_i) w_stateNext = IDLE;
         end
         IDLE, FRAME: begin
            if (bus.s_axis_tvalid_i) begin
               if (w_full) begin
                  // A full buffer on the last beat drops the frame without passing through DROP.
                  if (bus.s_axis_tlast_i) begin
                     w_wrPtrNext = r_wrCommit;
                     w_ovf       = 1'b1;
                     w_stateNext = IDLE;
                  end else begin
                     w_stateNext = DROP;
                  end
               end else begin
                  w_write     = 1'b1;
                  w_wrPtrNext = r_wrPtr + PW'(1);
                  if (bus.s_axis_tlast_i) begin
                     w_stateNext = IDLE;
                     if (bus.s_axis_tuser_i) begin
                        w_wrCommitNext = r_wrPtr + PW'(1);
                        w_good         = 1'b1;
                     end else begin
                        w_wrPtrNext = r_wrCommit;
                        w_bad       = 1'b1;
                     end
                  end else begin
                     w_stateNext = FRAME;
                  end
               end
            end
         end
         DROP: begin
            if (bus.s_axis_tvalid_i && bus.s_axis_tlast_i) begin
               w_wrPtrNext = r_wrCommit;
               w_ovf       = 1'b1;
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = SYNC;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state         <= SYNC;
         r_wrPtr         <= '0;
         r_wrCommit      <= '0;
         r_frameReceived <= 1'b0;
         r_frameDropped  <= 1'b0;
      end else begin
         r_state         <= w_stateNext;
         r_wrPtr         <= w_wrPtrNext;
         r_wrCommit      <= w_wrCommitNext;
         r_frameReceived <= w_good;
         r_frameDropped  <= w_bad | w_ovf;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_write && !reset_i)
         r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= {bus.s_axis_tlast_i, bus.s_axis_tkeep_i, bus.s_axis_tdata_i};
   end

   // The skid pair is filled straight from the RAM read, so a committed beat reaches the output one cycle later.
   assign w_pop  = (r_count != 2'd0) && bus.m_axis_tready_i;
   assign w_push = (r_rdPtr != r_wrCommit) && ((r_count != 2'd2) || w_pop);
   assign w_tail = r_head ^ r_count[0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rdPtr   <= '0;
         r_head    <= 1'b0;
         r_count   <= 2'd0;
         r_skid[0] <= '0;
         r_skid[1] <= '0;
      end else begin
         if (w_push) begin
            r_skid[w_tail] <= r_mem[r_rdPtr[DEPTH_LOG2-1:0]];
            r_rdPtr        <= r_rdPtr + PW'(1);
         end
         if (w_pop) r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign bus.m_axis_tvalid_o = (r_count != 2'd0);
   assign {bus.m_axis_tlast_o, bus.m_axis_tkeep_o, bus.m_axis_tdata_o} = r_skid[r_head];
   assign frame_received_o = r_frameReceived;
   assign frame_dropped_o  = r_frameDropped;

`ifdef RX_DROP_FIFO_STATS_EN
   logic [31:0] r_goodFrames, r_badFrames, r_overflowFrames;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_goodFrames     <= '0;
         r_badFrames      <= '0;
         r_overflowFrames <= '0;
      end else begin
         if (w_good) r_goodFrames     <= r_goodFrames + 32'd1;
         if (w_bad)  r_badFrames      <= r_badFrames + 32'd1;
         if (w_ovf)  r_overflowFrames <= r_overflowFrames + 32'd1;
      end
   end

   assign good_frames_o     = r_goodFrames;
   assign bad_frames_o      = r_badFrames;
   assign overflow_frames_o = r_overflowFrames;
`endif
endmodule
